// File: rtl/wb_width_adapter_pkg.sv
// Shared types and constants for the Wishbone width adapter.
package wb_width_adapter_pkg;

   localparam int ADR_W = 24;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      GAP,
      DONE
   } state_t;

endpackage

// File: rtl/wb_width_adapter.sv
// Wishbone width adapter: one BYTES-wide upstream access becomes BYTES
// little-endian single-byte accesses on the downstream (SPI SRAM) port.
// Optional feature: define WB_WIDTH_ADAPTER_READ_CACHE_EN for a
// single-entry read cache that answers repeated reads without SRAM traffic.
//
// state | meaning
// IDLE  | waiting for an upstream request
// ISSUE | load downstream address/data for byte k
// WAIT  | downstream strobe held until m_ack_i
// GAP   | one strobe-low cycle so the SRAM controller drops chip select
// DONE  | issue the upstream ack (if the master is still requesting)
module wb_width_adapter
   import wb_width_adapter_pkg::*;
#(
   parameter int BYTES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cyc_i,
   input  logic                 stb_i,
   input  logic [ADR_W-1:0]     adr_i,
   input  logic                 we_i,
   input  logic [8*BYTES-1:0]   dat_i,
   output logic                 ack_o,
   output logic                 err_o,
   output logic                 rty_o,
   output logic [8*BYTES-1:0]   dat_o,
   output logic                 m_cyc_o,
   output logic                 m_stb_o,
   output logic [ADR_W-1:0]     m_adr_o,
   output logic                 m_we_o,
   output logic [7:0]           m_dat_o,
   output logic [2:0]           m_cti_o,
   output logic [1:0]           m_bte_o,
   input  logic                 m_ack_i,
   input  logic [7:0]           m_dat_i
);

   localparam int DW = 8 * BYTES;
   localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q;
   logic [ADR_W-1:0]  base_q;
   logic              we_q;
   logic [DW-1:0]     wdat_q;
   logic [DW-1:0]     rbuf_q;
   logic              req;
   logic              hit;

   assign req     = cyc_i && stb_i;
   assign err_o   = 1'b0;
   assign rty_o   = 1'b0;
   assign m_cti_o = CTI_CLASSIC;
   assign m_bte_o = BTE_LINEAR;

`ifdef WB_WIDTH_ADAPTER_READ_CACHE_EN
   logic              cache_vld_q;
   logic [ADR_W-1:0]  cache_adr_q;
   logic [DW-1:0]     cache_dat_q;
   logic [ADR_W-1:0]  dist_fwd, dist_bwd;
   logic              wr_overlap;

   // Byte ranges overlap when either start lies within BYTES of the other,
   // measured modulo the 24-bit address space.
   assign dist_fwd   = adr_i - cache_adr_q;
   assign dist_bwd   = cache_adr_q - adr_i;
   assign wr_overlap = (dist_fwd < ADR_W'(BYTES)) || (dist_bwd < ADR_W'(BYTES));
   assign hit        = !we_i && cache_vld_q && (adr_i == cache_adr_q);
`else
   assign hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode; an upstream drop in any transfer state aborts to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req && !ack_o) state_d = hit ? DONE : ISSUE;
         ISSUE:   state_d = req ? WAIT : IDLE;
         WAIT: begin
            if (!req)         state_d = IDLE;
            else if (m_ack_i) state_d = (k_q == K_LAST) ? DONE : GAP;
         end
         GAP:     state_d = req ? ISSUE : IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture, registered downstream bus, read assembly and upstream ack.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_o   <= 1'b0;
         m_cyc_o <= 1'b0;
         m_stb_o <= 1'b0;
         m_we_o  <= 1'b0;
         m_adr_o <= '0;
         m_dat_o <= '0;
         dat_o   <= '0;
         k_q     <= '0;
         base_q  <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         rbuf_q  <= '0;
      end else begin
         ack_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req && !ack_o) begin
                  base_q <= adr_i;
                  we_q   <= we_i;
                  wdat_q <= dat_i;
                  k_q    <= '0;
`ifdef WB_WIDTH_ADAPTER_READ_CACHE_EN
                  if (hit) rbuf_q <= cache_dat_q;
`endif
               end
            end
            ISSUE: begin
               if (req) begin
                  m_cyc_o <= 1'b1;
                  m_stb_o <= 1'b1;
                  m_we_o  <= we_q;
                  m_adr_o <= base_q + ADR_W'(k_q);
                  m_dat_o <= wdat_q[8*k_q +: 8];
               end
            end
            WAIT: begin
               if (!req || m_ack_i) begin
                  m_cyc_o <= 1'b0;
                  m_stb_o <= 1'b0;
                  m_we_o  <= 1'b0;
               end
               if (req && m_ack_i) begin
                  if (!we_q) rbuf_q[8*k_q +: 8] <= m_dat_i;
                  if (k_q != K_LAST) k_q <= k_q + 1'b1;
               end
            end
            DONE: begin
               if (req) begin
                  ack_o <= 1'b1;
                  if (!we_q) dat_o <= rbuf_q;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef WB_WIDTH_ADAPTER_READ_CACHE_EN
   // Cache entry: filled by every completed read, dropped by overlapping writes and aborts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cache_vld_q <= 1'b0;
         cache_adr_q <= '0;
         cache_dat_q <= '0;
      end else if (state_q == IDLE && req && !ack_o && we_i && wr_overlap) begin
         cache_vld_q <= 1'b0;
      end else if ((state_q inside {ISSUE, WAIT, GAP}) && !req) begin
         cache_vld_q <= 1'b0;
      end else if (state_q == DONE && !we_q) begin
         cache_vld_q <= 1'b1;
         cache_adr_q <= base_q;
         cache_dat_q <= rbuf_q;
      end
   end
`endif

endmodule

// File: tb/tb_wb_width_adapter.sv
// Self-checking bench for wb_width_adapter: byte-wide SRAM slave with
// programmable ack latency, transaction-level reference model, literal checks.
module tb_wb_width_adapter;

   localparam int BYTES = 2;
   localparam int DW    = 8 * BYTES;
`ifdef WB_WIDTH_ADAPTER_READ_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [23:0]    adr_i = '0;
   logic [DW-1:0]  dat_i = '0;
   logic           ack_o, err_o, rty_o;
   logic [DW-1:0]  dat_o;
   logic           m_cyc_o, m_stb_o, m_we_o;
   logic [23:0]    m_adr_o;
   logic [7:0]     m_dat_o;
   logic [2:0]     m_cti_o;
   logic [1:0]     m_bte_o;
   logic           m_ack_i = 1'b0;
   logic [7:0]     m_dat_i = '0;

   wb_width_adapter #(.BYTES(BYTES)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i),
      .we_i(we_i), .dat_i(dat_i), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o),
      .dat_o(dat_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_adr_o(m_adr_o),
      .m_we_o(m_we_o), .m_dat_o(m_dat_o), .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
      .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [23:0] adr;
      logic [7:0]  dat;
   } ds_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;
   int ack_cnt  = 0;
   int ds_cnt   = 0;
   int slave_lat = 1;
   int s_cnt    = 0;

   ds_t exp_q[$];
   ds_t ds_log[$];
   logic [7:0] sram    [logic [23:0]];
   logic [7:0] ref_mem [logic [23:0]];

   logic [DW-1:0] last_rd = '0;
   logic          c_valid = 1'b0;
   logic [23:0]   c_adr   = '0;

   logic          prev_stb = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
   logic [23:0]   prev_adr = '0;
   logic [7:0]    prev_dat = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] sram_rd(input logic [23:0] a);
      return sram.exists(a) ? sram[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [23:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   always @(posedge clk_i) cyc_cnt++;

   // Downstream SRAM slave plus per-cycle protocol compare against expected accesses.
   always @(negedge clk_i) begin
      check("err_o_tied", err_o, 0);
      check("rty_o_tied", rty_o, 0);
      check("cti_classic", m_cti_o, 3'b000);
      check("bte_linear", m_bte_o, 2'b00);
      if (rst_i) begin
         m_ack_i  = 1'b0;
         s_cnt    = 0;
         prev_stb = 1'b0;
         prev_ack = 1'b0;
      end else begin
         if (ack_o) ack_cnt++;
         check("cyc_eq_stb", m_cyc_o, m_stb_o);
         if (m_stb_o) begin
            if (prev_ack) check("stb_gap_after_ack", prev_stb, 0);
            if (prev_stb && !prev_ack) begin
               check("hold_adr", m_adr_o, prev_adr);
               check("hold_we", m_we_o, prev_we);
               check("hold_dat", m_dat_o, prev_dat);
            end
            s_cnt++;
            if (s_cnt >= slave_lat) begin
               ds_t got;
               m_ack_i = 1'b1;
               m_dat_i = sram_rd(m_adr_o);
               if (m_we_o) sram[m_adr_o] = m_dat_o;
               s_cnt = 0;
               ds_cnt++;
               got.we = m_we_o; got.adr = m_adr_o; got.dat = m_dat_o;
               ds_log.push_back(got);
               check("ds_access_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  ds_t e;
                  e = exp_q.pop_front();
                  check("ds_adr", m_adr_o, e.adr);
                  check("ds_we", m_we_o, e.we);
                  if (e.we) check("ds_wdat", m_dat_o, e.dat);
               end
            end else begin
               m_ack_i = 1'b0;
               m_dat_i = 8'($urandom);
            end
         end else begin
            m_ack_i = 1'b0;
            s_cnt   = 0;
            m_dat_i = 8'($urandom);
         end
         prev_stb = m_stb_o;
         prev_ack = m_ack_i;
         prev_adr = m_adr_o;
         prev_we  = m_we_o;
         prev_dat = m_dat_o;
      end
   end

   // One upstream transfer: build expectations from the model, run it, retire it into the model.
   task automatic do_xfer(input logic we, input logic [23:0] adr, input logic [DW-1:0] wd,
                          input int lat, output logic [DW-1:0] rd, output int latency);
      logic          hit;
      int            exp_lat, acks0, t0;
      logic [DW-1:0] exp_rd;
      bit            got;
      hit     = CACHE_EN && !we && c_valid && (adr == c_adr);
      exp_lat = hit ? 2 : BYTES * (lat + 2) + 1;
      for (int k = 0; k < BYTES; k++) begin
         logic [23:0] a;
         ds_t e;
         a = adr + 24'(k);
         exp_rd[8*k +: 8] = ref_rd(a);
         e.we = we; e.adr = a; e.dat = wd[8*k +: 8];
         if (!hit) exp_q.push_back(e);
      end
      slave_lat = lat;
      acks0 = ack_cnt;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
      t0  = cyc_cnt;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk_i); #1;
         if (ack_o) got = 1'b1;
      end
      check("ack_seen", got, 1);
      latency = cyc_cnt - t0;
      if (got) check("latency", latency, exp_lat);
      if (we) check("dat_o_hold_on_write", dat_o, last_rd);
      else    check("rdata", dat_o, exp_rd);
      rd = dat_o;
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk_i); #1;
      check("ack_single_pulse", ack_cnt - acks0, 1);
      check("ack_low_after", ack_o, 0);
      check("ds_all_issued", exp_q.size(), 0);
      exp_q.delete();
      if (we) begin
         bit ovl;
         ovl = 1'b0;
         for (int i = 0; i < BYTES; i++) begin
            ref_mem[adr + 24'(i)] = wd[8*i +: 8];
            for (int j = 0; j < BYTES; j++)
               if (adr + 24'(i) == c_adr + 24'(j)) ovl = 1'b1;
         end
         if (ovl) c_valid = 1'b0;
      end else begin
         last_rd = exp_rd;
         c_valid = 1'b1;
         c_adr   = adr;
      end
   endtask

   task automatic check_log(input string name, input int idx, input logic we,
                            input logic [23:0] adr, input logic [7:0] dat);
      check({name, "_present"}, ds_log.size() > idx, 1);
      if (ds_log.size() > idx) begin
         check({name, "_adr"}, ds_log[idx].adr, adr);
         check({name, "_we"}, ds_log[idx].we, we);
         if (we) check({name, "_dat"}, ds_log[idx].dat, dat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] rd;
      int            lat_meas, n0, acks0;
      bit            seen;

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ack", ack_o, 0);
      check("rst_m_cyc", m_cyc_o, 0);
      check("rst_m_stb", m_stb_o, 0);
      check("rst_m_we", m_we_o, 0);
      check("rst_m_adr", m_adr_o, 0);
      check("rst_m_dat", m_dat_o, 0);
      check("rst_dat_o", dat_o, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      sram[24'h000100] = 8'h34;  sram[24'h000101] = 8'h12;
      ref_mem[24'h000100] = 8'h34; ref_mem[24'h000101] = 8'h12;
      n0 = ds_log.size();
      do_xfer(1'b0, 24'h000100, '0, 1, rd, lat_meas);
      check("lit_rd_1234", rd, 16'h1234);
      check("lit_rd_latency_L1", lat_meas, 7);
      check_log("lit_rd_b0", n0, 1'b0, 24'h000100, 8'h00);
      check_log("lit_rd_b1", n0 + 1, 1'b0, 24'h000101, 8'h00);

      n0 = ds_log.size();
      do_xfer(1'b1, 24'h000100, 16'hBEEF, 2, rd, lat_meas);
      check("lit_wr_latency_L2", lat_meas, 9);
      check("lit_wr_dat_o_kept", rd, 16'h1234);
      check_log("lit_wr_b0", n0, 1'b1, 24'h000100, 8'hEF);
      check_log("lit_wr_b1", n0 + 1, 1'b1, 24'h000101, 8'hBE);

      do_xfer(1'b0, 24'h000100, '0, 3, rd, lat_meas);
      check("lit_rd_beef", rd, 16'hBEEF);

      n0 = ds_log.size();
      do_xfer(1'b0, 24'hFFFFFF, '0, 1, rd, lat_meas);
      check_log("lit_wrap_b0", n0, 1'b0, 24'hFFFFFF, 8'h00);
      check_log("lit_wrap_b1", n0 + 1, 1'b0, 24'h000000, 8'h00);

      // Abort during WAIT of byte 0.
      slave_lat = 3;
      acks0 = ack_cnt;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 24'h000040; dat_i = '0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk_i); #1;
         if (m_stb_o) seen = 1'b1;
      end
      check("abort_stb_seen", seen, 1);
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk_i); #1;
      check("abort_stb_low", m_stb_o, 0);
      check("abort_cyc_low", m_cyc_o, 0);
      repeat (5) @(posedge clk_i);
      #1;
      check("abort_no_ack", ack_cnt - acks0, 0);
      c_valid = 1'b0;
      n0 = ds_log.size();
      do_xfer(1'b0, 24'h000040, '0, 2, rd, lat_meas);
      check_log("after_abort_k0", n0, 1'b0, 24'h000040, 8'h00);

      // Reset while in GAP after byte 0.
      begin
         ds_t e;
         int  d0;
         e.we = 1'b0; e.adr = 24'h000080; e.dat = '0;
         exp_q.push_back(e);
         slave_lat = 1;
         acks0 = ack_cnt;
         d0 = ds_cnt;
         cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 24'h000080;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_i); #1;
            if (ds_cnt != d0) seen = 1'b1;
         end
         check("gap_reached", seen, 1);
         rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
         @(posedge clk_i); #1;
         check("gaprst_ack", ack_o, 0);
         check("gaprst_m_cyc", m_cyc_o, 0);
         check("gaprst_m_stb", m_stb_o, 0);
         check("gaprst_m_we", m_we_o, 0);
         check("gaprst_m_adr", m_adr_o, 0);
         check("gaprst_m_dat", m_dat_o, 0);
         check("gaprst_dat_o", dat_o, 0);
         rst_i = 1'b0;
         check("gaprst_exp_consumed", exp_q.size(), 0);
         exp_q.delete();
         last_rd = '0;
         c_valid = 1'b0;
         @(posedge clk_i); #1;
         check("gaprst_no_ack", ack_cnt - acks0, 0);
         do_xfer(1'b0, 24'h000080, '0, 2, rd, lat_meas);
      end

      // Repeated read, then overlapping write, then read again.
      do_xfer(1'b0, 24'h000010, '0, 1, rd, lat_meas);
      n0 = ds_log.size();
      do_xfer(1'b0, 24'h000010, '0, 2, rd, lat_meas);
      check("reread_ds_count", ds_log.size() - n0, CACHE_EN ? 0 : 2);
      check("reread_latency", lat_meas, CACHE_EN ? 2 : 9);
      do_xfer(1'b1, 24'h000011, 16'hA55A, 1, rd, lat_meas);
      n0 = ds_log.size();
      do_xfer(1'b0, 24'h000010, '0, 1, rd, lat_meas);
      check("after_ovl_write_ds_count", ds_log.size() - n0, 2);

      // Randomized traffic around a small address window and the wrap point.
      for (int t = 0; t < 60; t++) begin
         logic        we;
         logic [23:0] adr;
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) adr = 24'hFFFFFE + 24'($urandom_range(0, 2));
         else                           adr = 24'h000010 + 24'($urandom_range(0, 5));
         do_xfer(we, adr, DW'($urandom), $urandom_range(1, 3), rd, lat_meas);
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_width_adapter.md
Name: wb_width_adapter

Overview:
- Wishbone width adapter placed directly upstream of the byte-wide SPI SRAM controller.
- Accepts one BYTES-wide upstream read or write.
- Splits it into BYTES sequential single-byte Wishbone accesses on the downstream port, then returns one upstream ack.
- Lets the accelerator core fetch multi-byte words from external SRAM in a single request.

Parameters:
- BYTES, 2, bytes per upstream word; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cyc_i  in  1  upstream cycle
- stb_i  in  1  upstream strobe
- adr_i  in  24  upstream byte address of byte 0
- we_i  in  1  upstream write enable
- dat_i  in  8*BYTES  upstream write data
- ack_o  out  1  upstream ack, one-cycle pulse
- err_o  out  1  tied 0
- rty_o  out  1  tied 0
- dat_o  out  8*BYTES  upstream read data
- m_cyc_o  out  1  downstream cycle
- m_stb_o  out  1  downstream strobe
- m_adr_o  out  24  downstream byte address
- m_we_o  out  1  downstream write enable
- m_dat_o  out  8  downstream write byte
- m_cti_o  out  3  constant 3'b000 (classic)
- m_bte_o  out  2  constant 2'b00 (linear)
- m_ack_i  in  1  downstream ack
- m_dat_i  in  8  downstream read byte

Behaviour:
- Reset (synchronous, rst_i high at clk_i edge):
  - state=IDLE.
  - ack_o, m_cyc_o, m_stb_o, m_we_o = 0.
  - m_adr_o = 0, m_dat_o = 0, dat_o = 0, byte index = 0.
  - Reset mid-transfer aborts immediately; no ack is issued.
- Byte order is little-endian: byte k occupies bits [8k+7:8k] and maps to address adr_i+k.
  - Address arithmetic is 24-bit modulo; 24'hFFFFFF+1 wraps to 0.
- IDLE:
  - When cyc_i && stb_i && !ack_o: latch adr_i, we_i, dat_i; k=0; go to ISSUE.
- ISSUE:
  - Assert m_cyc_o=m_stb_o=1, m_adr_o=base+k, m_we_o=we, m_dat_o=byte k; go to WAIT.
- WAIT:
  - Hold all downstream outputs stable until m_ack_i.
  - On m_ack_i: capture m_dat_i into dat_o byte k (reads only); deassert m_cyc_o/m_stb_o next cycle.
  - If k==BYTES-1, go to DONE; else k++ and go to GAP.
- GAP:
  - One cycle with m_stb_o=m_cyc_o=0, so the downstream controller releases chip select; then go to ISSUE.
- DONE:
  - ack_o=1 for exactly one cycle, only if cyc_i && stb_i are still high; then go to IDLE.
- Upstream abort: if cyc_i or stb_i drops in ISSUE, WAIT or GAP:
  - Drop m_cyc_o/m_stb_o next cycle and go to IDLE; no ack.
  - A partially written word is permitted.
- Latency: BYTES*(L+2)+1 cycles from request to ack, where L is the downstream request-to-ack latency.
- dat_o is valid in the ack cycle and holds until the next read completes; writes leave dat_o unchanged.
- A request arriving in the cycle after ack is accepted normally; the !ack_o guard prevents double-acceptance.

Optional Feature:
- Macro: WB_WIDTH_ADAPTER_READ_CACHE_EN.
- When defined, a single-entry read cache holds {valid, address, word}.
  - A read whose adr_i equals the cached address with valid=1 goes IDLE->DONE: ack on the 2nd cycle after acceptance, no downstream traffic, dat_o=cached word.
  - A completed read fills the cache.
  - Any accepted write with byte range overlapping the cached range clears valid. Overlap is computed modulo 2^24.
  - Reset and abort clear valid.
- When undefined: no cache logic; every read goes downstream.

Decomposition:
- Package wb_width_adapter_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, GAP, DONE}
  - CTI_CLASSIC=3'b000, BTE_LINEAR=2'b00
  - SRAM address width constant 24
- No sub-module; the optional cache sits inline under the macro.

Test Plan:
- BYTES=2 write adr=24'h000100, dat=16'hBEEF:
  - Downstream sees writes 8'hEF@0x000100, then 8'hBE@0x000101, with a stb-low gap cycle between.
  - Exactly one ack_o pulse.
- BYTES=2 read adr=24'h000100, model returns 8'h34 then 8'h12 -> dat_o=16'h1234 during ack_o.
- Read adr=24'hFFFFFF -> downstream addresses 24'hFFFFFF then 24'h000000.
- Drop cyc_i during WAIT of byte 0 -> m_stb_o low next cycle, ack_o never asserts, next request starts at k=0.
- Assert rst_i during GAP -> all outputs reset values next cycle; a subsequent read completes correctly.
- Cache build:
  - Read 0x10, read 0x10 again -> second read has zero downstream strobes and acks 2 cycles after acceptance.
  - Write 0x11 then read 0x10 -> downstream access occurs.
